// File: rtl/regbank_pkg.sv
// Shared types and constants for the grok80 register-bank write scheduler.
//   state_e            : scheduler FSM states (ARB, CLEAR)
//   REQ_ALU/LOAD/CTX   : fixed requester indices
//   DEFAULT_*          : default bank geometry
package regbank_pkg;

    typedef enum logic {ARB, CLEAR} state_e;

    localparam int unsigned REQ_ALU  = 0;
    localparam int unsigned REQ_LOAD = 1;
    localparam int unsigned REQ_CTX  = 2;

    localparam int unsigned DEFAULT_WIDTH    = 16;
    localparam int unsigned DEFAULT_NUM_REGS = 16;
    localparam int unsigned DEFAULT_NUM_REQ  = REQ_CTX + 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first valid requester searching upward (with wrap)
// from the one after the last winner.
//   req_valid_i : per-requester request
//   rr_last_i   : index of the previous winner
//   grant_o     : one-hot grant (all zero when nothing is valid)
//   winner_o    : index of the granted requester
//   any_valid_o : at least one request present
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [IDX_W-1:0]   rr_last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_valid_o
);

    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_o     = '0;
        winner_o    = '0;
        any_valid_o = 1'b0;
        // Offsets 1..NUM_REQ visit every requester once, the previous winner last.
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            idx = (32'(rr_last_i) + off) % NUM_REQ;
            if (!any_valid_o && req_valid_i[idx]) begin
                any_valid_o  = 1'b1;
                grant_o[idx] = 1'b1;
                winner_o     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regbank_write_sched.sv
// Write scheduler for the grok80 register bank (per-register dff with d/enable/q).
// Arbitrates NUM_REQ writeback requesters round-robin, one register write per cycle,
// and runs a synchronous bank-clear walk that zeroes one register per cycle.
//   clock, reset_n       : clock, synchronous active-low reset
//   req_valid/addr/data  : packed requester inputs (slice i belongs to requester i)
//   grant                : combinational one-hot accept
//   clear_req            : starts the clear walk (ignored while busy)
//   busy, clear_done     : walk in progress / one-cycle completion pulse
//   reg_en, reg_d        : registered one-hot enables and shared data bus for the bank
//   addr_err             : registered pulse for a granted write with addr >= NUM_REGS
// Build option: define REGBANK_ZERO_REG_EN to hardwire register 0 to zero (writes to
// address 0 are accepted but never enabled; the clear walk still enables it).
module regbank_write_sched
    import regbank_pkg::*;
#(
    parameter int unsigned WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned NUM_REGS = DEFAULT_NUM_REGS,
    parameter int unsigned NUM_REQ  = DEFAULT_NUM_REQ,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]  req_data,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      clear_req,
    output logic                      busy,
    output logic                      clear_done,
    output logic [NUM_REGS-1:0]       reg_en,
    output logic [WIDTH-1:0]          reg_d,
    output logic                      addr_err
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One extra bit so the walk counter can reach NUM_REGS (the wrap-up cycle).
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]    CntEnd = CNT_W'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] EnOne  = NUM_REGS'(1);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    rr_last_q, rr_last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
    logic [WIDTH-1:0]    wdata_q, wdata_d;
    logic                addr_err_q, addr_err_d;
    logic                clear_done_q, clear_done_d;
    logic                busy_q, busy_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [IDX_W-1:0]    arb_winner;
    logic                arb_any;
    logic [ADDR_W-1:0]   win_addr;
    logic [WIDTH-1:0]    win_data;
    logic                win_oob;
    logic                accept;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_valid_i (req_valid),
        .rr_last_i   (rr_last_q),
        .grant_o     (arb_grant),
        .winner_o    (arb_winner),
        .any_valid_o (arb_any)
    );

    assign win_addr = req_addr[32'(arb_winner) * ADDR_W +: ADDR_W];
    assign win_data = req_data[32'(arb_winner) * WIDTH +: WIDTH];
    assign win_oob  = {1'b0, win_addr} >= CntEnd;

    // A clear request pre-empts any write in the same cycle.
    assign accept = reset_n && (state_q == ARB) && !clear_req && arb_any;
    assign grant  = accept ? arb_grant : '0;

    always_comb begin
        state_d      = state_q;
        rr_last_d    = rr_last_q;
        cnt_d        = cnt_q;
        reg_en_d     = '0;
        wdata_d      = wdata_q;
        addr_err_d   = 1'b0;
        clear_done_d = 1'b0;
        unique case (state_q)
            ARB: begin
                if (clear_req) begin
                    // Register 0 is enabled on the entry edge; cnt tracks the next one.
                    state_d  = CLEAR;
                    reg_en_d = EnOne;
                    wdata_d  = '0;
                    cnt_d    = CNT_W'(1);
                end else if (accept) begin
                    rr_last_d  = arb_winner;
                    wdata_d    = win_data;
                    addr_err_d = win_oob;
                    if (!win_oob) begin
                        reg_en_d = EnOne << win_addr;
                    end
`ifdef REGBANK_ZERO_REG_EN
                    if (win_addr == '0) begin
                        reg_en_d = '0;
                    end
`endif
                end
            end
            CLEAR: begin
                if (cnt_q == CntEnd) begin
                    // Last enable is on the bus this cycle; it lands at this edge.
                    state_d      = ARB;
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                end else begin
                    reg_en_d = EnOne << cnt_q;
                    wdata_d  = '0;
                    cnt_d    = cnt_q + CNT_W'(1);
                end
            end
        endcase
        busy_d = (state_d == CLEAR);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q      <= ARB;
            rr_last_q    <= IDX_W'(NUM_REQ - 1);
            cnt_q        <= '0;
            reg_en_q     <= '0;
            wdata_q      <= '0;
            addr_err_q   <= 1'b0;
            clear_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_last_q    <= rr_last_d;
            cnt_q        <= cnt_d;
            reg_en_q     <= reg_en_d;
            wdata_q      <= wdata_d;
            addr_err_q   <= addr_err_d;
            clear_done_q <= clear_done_d;
            busy_q       <= busy_d;
        end
    end

    assign reg_en     = reg_en_q;
    assign reg_d      = wdata_q;
    assign addr_err   = addr_err_q;
    assign clear_done = clear_done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_regbank_write_sched.sv
// Bench for regbank_write_sched: directed scenarios plus randomized traffic checked
// against a cycle-schedule reference model and a behavioural dff bank.
module tb_regbank_write_sched;

    localparam int NREQ  = 3;
    localparam int NREGS = 16;

    logic        clock;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  grant;
    logic        clear_req;
    logic        busy;
    logic        clear_done;
    logic [15:0] reg_en;
    logic [15:0] reg_d;
    logic        addr_err;

    // Second instance with a non-power-of-two bank for out-of-range addresses.
    logic        r12_rst_n;
    logic [2:0]  r12_valid;
    logic [11:0] r12_addr;
    logic [47:0] r12_data;
    logic [2:0]  r12_grant;
    logic        r12_busy;
    logic        r12_done;
    logic [11:0] r12_reg_en;
    logic [15:0] r12_reg_d;
    logic        r12_err;

    regbank_write_sched #(
        .WIDTH    (16),
        .NUM_REGS (16),
        .NUM_REQ  (3)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .grant      (grant),
        .clear_req  (clear_req),
        .busy       (busy),
        .clear_done (clear_done),
        .reg_en     (reg_en),
        .reg_d      (reg_d),
        .addr_err   (addr_err)
    );

    regbank_write_sched #(
        .WIDTH    (16),
        .NUM_REGS (12),
        .NUM_REQ  (3)
    ) dut12 (
        .clock      (clock),
        .reset_n    (r12_rst_n),
        .req_valid  (r12_valid),
        .req_addr   (r12_addr),
        .req_data   (r12_data),
        .grant      (r12_grant),
        .clear_req  (1'b0),
        .busy       (r12_busy),
        .clear_done (r12_done),
        .reg_en     (r12_reg_en),
        .reg_d      (r12_reg_d),
        .addr_err   (r12_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural register bank driven by the scheduler (the dffs it controls).
    logic [15:0] bank_q [NREGS] = '{default: '0};
    always @(posedge clock) begin
        for (int i = 0; i < NREGS; i++) begin
            if (reg_en[i]) bank_q[i] <= reg_d;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Requester behaviour: hold request until granted, optionally refill afterwards.
    logic        rq_v [NREQ];
    logic [3:0]  rq_a [NREQ];
    logic [15:0] rq_d [NREQ];
    int          refill_pct = 0;

    // Reference model state.
    logic [15:0] m_bank [NREGS] = '{default: '0};
    int          m_rr;
    bit          m_known = 0;
    bit          walk_on = 0;
    int          clr_k   = 0;
    logic [15:0] e_en, e_d;
    logic        e_err, e_done, e_busy;

    function automatic logic [15:0] onehot16(input int i);
        onehot16 = '0;
        if (i >= 0 && i < NREGS) onehot16[i] = 1'b1;
    endfunction

    task automatic run_cycle(input bit rst_n, input bit clr);
        logic [2:0] eg;
        int win;
        int w;
        @(posedge clock);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (!rq_v[i] && $urandom_range(99) < refill_pct) begin
                rq_v[i] = 1'b1;
                rq_a[i] = 4'($urandom_range(NREGS - 1));
                rq_d[i] = 16'($urandom);
            end
        end
        reset_n   = rst_n;
        clear_req = clr;
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]          = rq_v[i];
            req_addr[i*4 +: 4]    = rq_a[i];
            req_data[i*16 +: 16]  = rq_d[i];
        end
        @(negedge clock);

        // Expected grant: none during reset, the walk, or a clear request.
        w   = walk_on ? (cyc - clr_k) : 0;
        eg  = '0;
        win = -1;
        if (rst_n && !walk_on && !clr) begin
            for (int o = 1; o <= NREQ; o++) begin
                int c;
                c = (m_rr + o) % NREQ;
                if (win < 0 && rq_v[c]) win = c;
            end
            if (win >= 0) eg[win] = 1'b1;
        end
        check_eq("grant", 32'(grant), 32'(eg));
        if (m_known) begin
            check_eq("reg_en", 32'(reg_en), 32'(e_en));
            check_eq("reg_d", 32'(reg_d), 32'(e_d));
            check_eq("addr_err", 32'(addr_err), 32'(e_err));
            check_eq("busy", 32'(busy), 32'(e_busy));
            check_eq("clear_done", 32'(clear_done), 32'(e_done));
            for (int i = 0; i < NREGS; i++) begin
                check_eq($sformatf("bank[%0d]", i), 32'(bank_q[i]), 32'(m_bank[i]));
            end
            for (int i = 0; i < NREGS; i++) begin
                if (e_en[i]) m_bank[i] = e_d;
            end
        end

        // Expected registered outputs for the next cycle.
        e_err  = 1'b0;
        e_done = 1'b0;
        if (!rst_n) begin
            e_en    = '0;
            e_d     = '0;
            e_busy  = 1'b0;
            m_rr    = NREQ - 1;
            walk_on = 0;
            m_known = 1;
        end else if (walk_on) begin
            if (w < NREGS) begin
                e_en   = onehot16(w);
                e_d    = '0;
                e_busy = 1'b1;
            end else begin
                e_en    = '0;
                e_busy  = 1'b0;
                e_done  = 1'b1;
                walk_on = 0;
            end
        end else if (clr) begin
            walk_on = 1;
            clr_k   = cyc;
            e_en    = onehot16(0);
            e_d     = '0;
            e_busy  = 1'b1;
        end else if (win >= 0) begin
            e_en  = onehot16(int'(rq_a[win]));
`ifdef REGBANK_ZERO_REG_EN
            if (rq_a[win] == 4'd0) e_en = '0;
`endif
            e_d   = rq_d[win];
            e_err = (int'(rq_a[win]) >= NREGS);
            m_rr  = win;
            rq_v[win] = 1'b0;
        end else begin
            e_en = '0;
        end
        cyc++;
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [15:0] d);
        rq_v[i] = 1'b1;
        rq_a[i] = a;
        rq_d[i] = d;
    endtask

    initial begin
        reset_n   = 1'b0;
        clear_req = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        r12_rst_n = 1'b0;
        r12_valid = '0;
        r12_addr  = '0;
        r12_data  = '0;
        e_en = '0; e_d = '0; e_err = 1'b0; e_done = 1'b0; e_busy = 1'b0;
        m_rr = NREQ - 1;
        for (int i = 0; i < NREQ; i++) begin
            rq_v[i] = 1'b0;
            rq_a[i] = '0;
            rq_d[i] = '0;
        end

        // Reset: a pending request must not be granted while reset_n is low.
        set_req(0, 4'd7, 16'h1111);
        run_cycle(0, 0);
        run_cycle(0, 0);
        rq_v[0] = 1'b0;
        run_cycle(0, 0);

        // Single write: addr 5, data BEEF from the ALU.
        set_req(0, 4'd5, 16'hBEEF);
        repeat (4) run_cycle(1, 0);

        // Round robin with all three continuously valid from reset.
        run_cycle(0, 0);
        set_req(0, 4'd1, 16'h0A01);
        set_req(1, 4'd2, 16'h0B02);
        set_req(2, 4'd3, 16'h0C03);
        refill_pct = 100;
        repeat (8) run_cycle(1, 0);
        refill_pct = 0;
        repeat (4) run_cycle(1, 0);

        // Clear vs request in the same cycle; a mid-walk clear_req is ignored.
        set_req(0, 4'd9, 16'h5A5A);
        run_cycle(1, 1);
        repeat (6) run_cycle(1, 0);
        run_cycle(1, 1);
        repeat (14) run_cycle(1, 0);

        // Reset during the 6th clear cycle, then requester 0 must win first.
        set_req(0, 4'd4, 16'h4444);
        set_req(1, 4'd6, 16'h6666);
        set_req(2, 4'd8, 16'h8888);
        run_cycle(1, 1);
        repeat (5) run_cycle(1, 0);
        run_cycle(0, 0);
        repeat (5) run_cycle(1, 0);

        // Register 0 write (hardwired zero when the option is built in).
        set_req(1, 4'd0, 16'h1234);
        repeat (4) run_cycle(1, 0);

        // Randomized traffic with occasional clears and resets.
        refill_pct = 35;
        for (int n = 0; n < 600; n++) begin
            run_cycle(($urandom_range(249) != 0), ($urandom_range(99) < 3));
        end
        refill_pct = 0;
        repeat (20) run_cycle(1, 0);

        // Out-of-range address on a 12-register bank.
        @(posedge clock);
        #1;
        r12_rst_n = 1'b1;
        r12_valid = 3'b001;
        r12_addr  = {4'd0, 4'd0, 4'd13};
        r12_data  = {16'h0000, 16'h0000, 16'hA5A5};
        @(negedge clock);
        check_eq("oob_grant", 32'(r12_grant), 32'h1);
        @(posedge clock);
        #1;
        r12_valid = 3'b100;
        r12_addr  = {4'd11, 4'd0, 4'd0};
        r12_data  = {16'h1111, 16'h0000, 16'h0000};
        @(negedge clock);
        check_eq("oob_reg_en", 32'(r12_reg_en), 32'h0);
        check_eq("oob_addr_err", 32'(r12_err), 32'h1);
        check_eq("top_grant", 32'(r12_grant), 32'h4);
        @(posedge clock);
        #1;
        r12_valid = 3'b000;
        @(negedge clock);
        check_eq("top_reg_en", 32'(r12_reg_en), 32'h800);
        check_eq("top_reg_d", 32'(r12_reg_d), 32'h1111);
        check_eq("top_addr_err", 32'(r12_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
